int_ret_ctrl: RTL and testbench

Interrupt/return sequencer sitting between the interrupt source, AP_ctrl and the program counter. On an interrupt it saves the current instruction address on an internal return-address stack, pulses `int` and drives `jmp_addr_pc` to the vectored ISR entry. On a RET it pops the saved address and runs the `ret_valid` / `ret_addr_pc` / `ret_addr_pc_rdy` handshake the program counter consumes. It owns nesting, stack overflow/underflow and int/ret collision policy.

---
 rtl/ap_int_pkg.sv | 21 ++
 rtl/ret_addr_lifo.sv | 50 +++++
 rtl/int_ret_ctrl.sv | 147 ++++++++++++++
 tb/tb_int_ret_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ap_int_pkg.sv
// Shared types and constants for the interrupt/return sequencer.
package ap_int_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH     = 3'd1,
    JMP_WAIT = 3'd2,
    POP      = 3'd3,
    RET_RDY  = 3'd4,
    RET_DROP = 3'd5
  } state_t;

  localparam logic [27:0] ISR_BASE_DEF   = 28'h0000400;
  localparam logic [27:0] ISR_STRIDE_DEF = 28'h0000040;

  // Occupancy counter width: must be able to hold the value DEPTH itself.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/ret_addr_lifo.sv
// Return-address LIFO: synchronous write, registered read, unreset storage.
// CAP limits usable entries below DEPTH when nesting is disabled.
module ret_addr_lifo
  import ap_int_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  parameter int CAP   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data,
  output logic [sp_width(DEPTH)-1:0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = sp_width(DEPTH);
  localparam logic [SPW-1:0] ONE = SPW'(32'd1);

  logic [WIDTH-1:0] mem_r [DEPTH];

  assign full  = (count == SPW'(CAP));
  assign empty = (count == {SPW{1'b0}});

  // Storage write, no reset on the array
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[AW'(count)] <= wr_data;
    end
  end

  // Occupancy pointer and registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= {SPW{1'b0}};
      rd_data <= {WIDTH{1'b0}};
    end else if (push && !full) begin
      count <= count + ONE;
    end else if (pop && !empty) begin
      rd_data <= mem_r[AW'(count - ONE)];
      count   <= count - ONE;
    end
  end

endmodule

// File: rtl/int_ret_ctrl.sv
// Interrupt entry / RET sequencer with return-address stack.
// Define INT_NEST_EN for nested interrupts up to STACK_DEPTH; otherwise one level.
module int_ret_ctrl
  import ap_int_pkg::*;
#(
  parameter int ADDR_WIDTH_MEM = 16,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int STACK_DEPTH    = 4,
  parameter logic [DDR_ADDR_WIDTH-1:0] ISR_BASE   = DDR_ADDR_WIDTH'(ISR_BASE_DEF),
  parameter logic [DDR_ADDR_WIDTH-1:0] ISR_STRIDE = DDR_ADDR_WIDTH'(ISR_STRIDE_DEF)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              int_req,
  input  logic [1:0]                        int_id,
  input  logic                              ret_req,
  input  logic                              ins_inp_valid,
  input  logic [ADDR_WIDTH_MEM-1:0]         addr_cur_ins,
  output logic                              int_pulse,
  output logic [DDR_ADDR_WIDTH-1:0]         jmp_addr_pc,
  output logic                              ret_valid,
  output logic [ADDR_WIDTH_MEM-1:0]         ret_addr_pc,
  output logic                              ret_addr_pc_rdy,
  output logic                              busy,
  output logic [sp_width(STACK_DEPTH)-1:0]  sp,
  output logic                              err_ovf,
  output logic                              err_udf
);

`ifdef INT_NEST_EN
  localparam int   STACK_CAP = STACK_DEPTH;
  localparam logic NEST      = 1'b1;
`else
  localparam int   STACK_CAP = 1;
  localparam logic NEST      = 1'b0;
`endif

  state_t                    state_r, next_s;
  logic                      int_req_d_r, int_pending_r;
  logic [1:0]                int_id_r;
  logic                      edge_s, full_s, empty_s;
  logic                      push_s, pop_s, ovf_set_s, udf_set_s;
  logic [DDR_ADDR_WIDTH-1:0] jmp_target_s;

  assign edge_s       = int_req & ~int_req_d_r;
  assign jmp_target_s = ISR_BASE + DDR_ADDR_WIDTH'(int_id_r) * ISR_STRIDE;

  ret_addr_lifo #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH_MEM),
    .CAP   (STACK_CAP)
  ) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data (addr_cur_ins),
    .rd_data (ret_addr_pc),
    .count   (sp),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Interrupt edge detect and pending latch; later edges are ignored while pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_req_d_r   <= 1'b0;
      int_pending_r <= 1'b0;
      int_id_r      <= 2'd0;
    end else begin
      int_req_d_r <= int_req;
      if (state_r == PUSH) begin
        int_pending_r <= 1'b0;
      end else if (edge_s && !int_pending_r) begin
        int_pending_r <= 1'b1;
        int_id_r      <= int_id;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic: RET wins over a pending interrupt in IDLE
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (ret_req) begin
          if (!empty_s) next_s = POP;
          else          next_s = IDLE;
        end else if (int_pending_r && !full_s) begin
          next_s = PUSH;
        end else begin
          next_s = IDLE;
        end
      end
      PUSH:     next_s = JMP_WAIT;
      JMP_WAIT: begin
        if (ins_inp_valid) next_s = IDLE;
        else               next_s = JMP_WAIT;
      end
      POP:      next_s = RET_RDY;
      RET_RDY:  next_s = RET_DROP;
      RET_DROP: next_s = IDLE;
      default:  next_s = IDLE;
    endcase
  end

  // Stack strobes and error set conditions
  always_comb begin
    push_s    = (state_r == PUSH);
    pop_s     = (state_r == POP);
    udf_set_s = ret_req && ((state_r != IDLE) || empty_s);
    ovf_set_s = NEST && (state_r == IDLE) && !ret_req && int_pending_r && full_s;
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_pulse       <= 1'b0;
      jmp_addr_pc     <= {DDR_ADDR_WIDTH{1'b0}};
      ret_valid       <= 1'b0;
      ret_addr_pc_rdy <= 1'b0;
      busy            <= 1'b0;
      err_ovf         <= 1'b0;
      err_udf         <= 1'b0;
    end else begin
      int_pulse       <= (next_s == PUSH);
      ret_valid       <= (next_s == POP) || (next_s == RET_RDY);
      ret_addr_pc_rdy <= (next_s == RET_RDY);
      busy            <= (next_s != IDLE);
      err_ovf         <= err_ovf | ovf_set_s;
      err_udf         <= err_udf | udf_set_s;
      if (next_s == PUSH) begin
        jmp_addr_pc <= jmp_target_s;
      end
    end
  end

endmodule

// File: tb/tb_int_ret_ctrl.sv
// Table-driven scoreboard bench for int_ret_ctrl; follows INT_NEST_EN if defined.
module tb_int_ret_ctrl;

  typedef struct packed {
    logic        ret;
    logic        irq;
    logic [1:0]  id;
    logic        iv;
    logic [15:0] addr;
  } in_t;

  typedef struct packed {
    logic        intp;
    logic [27:0] jmp;
    logic        rv;
    logic [15:0] ra;
    logic        rdy;
    logic        busy;
    logic [2:0]  sp;
    logic        ovf;
    logic        udf;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        int_req = 1'b0;
  logic [1:0]  int_id = 2'd0;
  logic        ret_req = 1'b0;
  logic        ins_inp_valid = 1'b0;
  logic [15:0] addr_cur_ins = 16'h0000;
  logic        int_pulse, ret_valid, ret_addr_pc_rdy, busy, err_ovf, err_udf;
  logic [27:0] jmp_addr_pc;
  logic [15:0] ret_addr_pc;
  logic [2:0]  sp;
  out_t        act_s;

  int   n_vec = 0;
  int   n_err = 0;
  out_t exp_q[$];
  vec_t tbl[22];

  int_ret_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .int_req         (int_req),
    .int_id          (int_id),
    .ret_req         (ret_req),
    .ins_inp_valid   (ins_inp_valid),
    .addr_cur_ins    (addr_cur_ins),
    .int_pulse       (int_pulse),
    .jmp_addr_pc     (jmp_addr_pc),
    .ret_valid       (ret_valid),
    .ret_addr_pc     (ret_addr_pc),
    .ret_addr_pc_rdy (ret_addr_pc_rdy),
    .busy            (busy),
    .sp              (sp),
    .err_ovf         (err_ovf),
    .err_udf         (err_udf)
  );

  always #5 clk = ~clk;

  assign act_s = {int_pulse, jmp_addr_pc, ret_valid, ret_addr_pc, ret_addr_pc_rdy,
                  busy, sp, err_ovf, err_udf};

  task automatic compare(input string name);
    out_t e;
    e = exp_q.pop_front();
    n_vec++;
    if (act_s !== e) begin
      n_err++;
      $display("FAIL %s: got int=%b jmp=%h rv=%b ra=%h rdy=%b busy=%b sp=%0d ovf=%b udf=%b, want int=%b jmp=%h rv=%b ra=%h rdy=%b busy=%b sp=%0d ovf=%b udf=%b",
               name, act_s.intp, act_s.jmp, act_s.rv, act_s.ra, act_s.rdy, act_s.busy,
               act_s.sp, act_s.ovf, act_s.udf, e.intp, e.jmp, e.rv, e.ra, e.rdy, e.busy,
               e.sp, e.ovf, e.udf);
    end
  endtask

  task automatic step(input in_t i, input out_t o, input string name);
    @(negedge clk);
    ret_req       = i.ret;
    int_req       = i.irq;
    int_id        = i.id;
    ins_inp_valid = i.iv;
    addr_cur_ins  = i.addr;
    exp_q.push_back(o);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_t  i;
    out_t e;

    // inputs: ret, irq, id, iv, addr | outputs after the edge: int, jmp, rv, ra, rdy, busy, sp, ovf, udf
    tbl[0]  = '{'{1'b0,1'b1,2'd2,1'b0,16'h0023}, '{1'b0,28'h000,1'b0,16'h0000,1'b0,1'b0,3'd0,1'b0,1'b0}};
    tbl[1]  = '{'{1'b0,1'b1,2'd2,1'b0,16'h0023}, '{1'b1,28'h480,1'b0,16'h0000,1'b0,1'b1,3'd0,1'b0,1'b0}};
    tbl[2]  = '{'{1'b0,1'b0,2'd2,1'b0,16'h0023}, '{1'b0,28'h480,1'b0,16'h0000,1'b0,1'b1,3'd1,1'b0,1'b0}};
    tbl[3]  = '{'{1'b0,1'b0,2'd0,1'b1,16'h0023}, '{1'b0,28'h480,1'b0,16'h0000,1'b0,1'b0,3'd1,1'b0,1'b0}};
    tbl[4]  = '{'{1'b0,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b0,16'h0000,1'b0,1'b0,3'd1,1'b0,1'b0}};
    tbl[5]  = '{'{1'b1,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b1,16'h0000,1'b0,1'b1,3'd1,1'b0,1'b0}};
    tbl[6]  = '{'{1'b0,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b1,16'h0023,1'b1,1'b1,3'd0,1'b0,1'b0}};
    tbl[7]  = '{'{1'b0,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b0,16'h0023,1'b0,1'b1,3'd0,1'b0,1'b0}};
    tbl[8]  = '{'{1'b0,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b0,16'h0023,1'b0,1'b0,3'd0,1'b0,1'b0}};
    tbl[9]  = '{'{1'b1,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b0,16'h0023,1'b0,1'b0,3'd0,1'b0,1'b1}};
    tbl[10] = '{'{1'b0,1'b0,2'd0,1'b0,16'h0000}, '{1'b0,28'h480,1'b0,16'h0023,1'b0,1'b0,3'd0,1'b0,1'b1}};
    tbl[11] = '{'{1'b0,1'b1,2'd1,1'b0,16'h0100}, '{1'b0,28'h480,1'b0,16'h0023,1'b0,1'b0,3'd0,1'b0,1'b1}};
    tbl[12] = '{'{1'b0,1'b1,2'd1,1'b0,16'h0100}, '{1'b1,28'h440,1'b0,16'h0023,1'b0,1'b1,3'd0,1'b0,1'b1}};
    tbl[13] = '{'{1'b0,1'b0,2'd1,1'b0,16'h0100}, '{1'b0,28'h440,1'b0,16'h0023,1'b0,1'b1,3'd1,1'b0,1'b1}};
    tbl[14] = '{'{1'b0,1'b0,2'd0,1'b1,16'h0100}, '{1'b0,28'h440,1'b0,16'h0023,1'b0,1'b0,3'd1,1'b0,1'b1}};
    tbl[15] = '{'{1'b1,1'b1,2'd3,1'b0,16'h0200}, '{1'b0,28'h440,1'b1,16'h0023,1'b0,1'b1,3'd1,1'b0,1'b1}};
    tbl[16] = '{'{1'b0,1'b1,2'd3,1'b0,16'h0200}, '{1'b0,28'h440,1'b1,16'h0100,1'b1,1'b1,3'd0,1'b0,1'b1}};
    tbl[17] = '{'{1'b0,1'b1,2'd3,1'b0,16'h0200}, '{1'b0,28'h440,1'b0,16'h0100,1'b0,1'b1,3'd0,1'b0,1'b1}};
    tbl[18] = '{'{1'b0,1'b1,2'd3,1'b0,16'h0200}, '{1'b0,28'h440,1'b0,16'h0100,1'b0,1'b0,3'd0,1'b0,1'b1}};
    tbl[19] = '{'{1'b0,1'b1,2'd3,1'b0,16'h0200}, '{1'b1,28'h4C0,1'b0,16'h0100,1'b0,1'b1,3'd0,1'b0,1'b1}};
    tbl[20] = '{'{1'b0,1'b0,2'd3,1'b0,16'h0200}, '{1'b0,28'h4C0,1'b0,16'h0100,1'b0,1'b1,3'd1,1'b0,1'b1}};
    tbl[21] = '{'{1'b0,1'b0,2'd0,1'b1,16'h0200}, '{1'b0,28'h4C0,1'b0,16'h0100,1'b0,1'b0,3'd1,1'b0,1'b1}};

    e = '0;
    exp_q.push_back(e);
    #12;
    compare("reset_state");
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 22; k++) begin
      step(tbl[k].i, tbl[k].o, $sformatf("tbl%0d", k));
    end

    e = tbl[21].o;
`ifdef INT_NEST_EN
    // Fill the stack to 4, then a fifth interrupt is refused and held pending
    for (int k = 1; k <= 3; k++) begin
      i = '0; i.irq = 1'b1; i.id = 2'(k); i.addr = 16'h0300 + 16'(k);
      step(i, e, "nest_req");
      e.intp = 1'b1; e.jmp = 28'h400 + 28'(k) * 28'h40; e.busy = 1'b1;
      step(i, e, "nest_push");
      i.irq = 1'b0; e.intp = 1'b0; e.sp = e.sp + 3'd1;
      step(i, e, "nest_sp");
      i.iv = 1'b1; e.busy = 1'b0;
      step(i, e, "nest_idle");
    end
    i = '0; i.irq = 1'b1; i.id = 2'd0; i.addr = 16'h0400;
    step(i, e, "ovf_req");
    e.ovf = 1'b1;
    step(i, e, "ovf_set");
    i.irq = 1'b0;
    step(i, e, "ovf_hold");
    i.ret = 1'b1; e.rv = 1'b1; e.busy = 1'b1;
    step(i, e, "ovf_ret");
    i.ret = 1'b0; e.ra = 16'h0303; e.sp = 3'd3; e.rdy = 1'b1;
    step(i, e, "ovf_pop");
`else
    // Single level: a second interrupt waits without flagging overflow
    i = '0; i.irq = 1'b1; i.id = 2'd0; i.addr = 16'h0300;
    step(i, e, "nn_req");
    step(i, e, "nn_hold");
    i.irq = 1'b0;
    step(i, e, "nn_hold2");
    i.ret = 1'b1; e.rv = 1'b1; e.busy = 1'b1;
    step(i, e, "nn_ret");
    i.ret = 1'b0; e.ra = 16'h0200; e.sp = 3'd0; e.rdy = 1'b1;
    step(i, e, "nn_pop");
`endif
    e.rv = 1'b0; e.rdy = 1'b0;
    step(i, e, "pend_drop");
    e.busy = 1'b0;
    step(i, e, "pend_idle");
    e.intp = 1'b1; e.jmp = 28'h400; e.busy = 1'b1;
    step(i, e, "pend_push");
    e.intp = 1'b0; e.sp = e.sp + 3'd1;
    step(i, e, "pend_sp");
    i.iv = 1'b1; e.busy = 1'b0;
    step(i, e, "pend_done");

    // Asynchronous reset while in RET_RDY
    i = '0; i.ret = 1'b1; e.rv = 1'b1; e.busy = 1'b1;
    step(i, e, "rst_ret");
    i.ret = 1'b0; e.ra = (e.sp == 3'd4) ? 16'h0400 : 16'h0300; e.sp = e.sp - 3'd1; e.rdy = 1'b1;
    step(i, e, "rst_rdy");
    #1;
    rst = 1'b0;
    e = '0;
    exp_q.push_back(e);
    #1;
    compare("rst_async");
    @(negedge clk);
    rst = 1'b1;
    step(i, e, "post_rst_idle");
    i.irq = 1'b1; i.id = 2'd1; i.addr = 16'h0055;
    step(i, e, "post_req");
    e.intp = 1'b1; e.jmp = 28'h440; e.busy = 1'b1;
    step(i, e, "post_push");
    i.irq = 1'b0; e.intp = 1'b0; e.sp = 3'd1;
    step(i, e, "post_sp");
    i.iv = 1'b1; e.busy = 1'b0;
    step(i, e, "post_idle");
    i = '0; i.ret = 1'b1; e.rv = 1'b1; e.busy = 1'b1;
    step(i, e, "post_ret");
    i.ret = 1'b0; e.ra = 16'h0055; e.sp = 3'd0; e.rdy = 1'b1;
    step(i, e, "post_pop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
